// File: rtl/bpht_update_sched_if.sv
// Port bundle for the BPHT write-side scheduler: EX update strobe, IF read probe,
// flush, and the table's single write port.
interface bpht_update_sched_if #(
  parameter int unsigned h_width = 8
);
  logic               update_en;
  logic [2:0]         kind_ex;
  logic [h_width-1:0] pc_ex_bh_hashed;
  logic               taken_real;
  logic [1:0]         taken_pdch_ex_b;
  logic               flush_all;
  logic               pred_valid;
  logic [h_width-1:0] pc_bh_hashed;
  logic               pht_we;
  logic [h_width-1:0] pht_waddr;
  logic [1:0]         pht_wdata;
  logic               init_busy;
  logic [15:0]        drop_cnt;

  modport master (
    output update_en, kind_ex, pc_ex_bh_hashed, taken_real, taken_pdch_ex_b,
    output flush_all, pred_valid, pc_bh_hashed,
    input  pht_we, pht_waddr, pht_wdata, init_busy, drop_cnt
  );

  modport slave (
    input  update_en, kind_ex, pc_ex_bh_hashed, taken_real, taken_pdch_ex_b,
    input  flush_all, pred_valid, pc_bh_hashed,
    output pht_we, pht_waddr, pht_wdata, init_busy, drop_cnt
  );
endinterface

// File: rtl/bpht_update_sched.sv
// BPHT write-side controller: 2-bit counter update, small write FIFO drained around
// same-index prediction reads, and a full-table sweep to weakly-not-taken on reset/flush.
module bpht_update_sched #(
  parameter int unsigned h_width = 8,
  parameter int unsigned DEPTH   = 4
) (
  input logic               clk,
  input logic               rstn,
  bpht_update_sched_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic {INIT, RUN} state_t;

  state_t             state, state_nxt;
  logic [h_width-1:0] sweep_idx;
  logic [h_width-1:0] fifo_idx [DEPTH];
  logic [1:0]         fifo_ctr [DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [PW:0]        count;
  logic               deferred_last;
  logic [15:0]        drop_q;

  logic [1:0] pdch, ctr_new;
  logic       candidate, push_req, push, pop, drop;
  logic       empty, full, defer, sweep_last;

  always_comb begin
    pdch = bus.taken_pdch_ex_b;
    if (bus.taken_real) ctr_new = (pdch == 2'd3) ? 2'd3 : pdch + 2'd1;
    else                ctr_new = (pdch == 2'd0) ? 2'd0 : pdch - 2'd1;
  end

  always_comb begin
    empty      = (count == '0);
    full       = (count == FULL_CNT);
    sweep_last = (sweep_idx == '1);
    defer      = bus.pred_valid && (fifo_idx[rd_ptr] == bus.pc_bh_hashed) && !deferred_last;
    pop        = (state == RUN) && !empty && !defer;
    candidate  = bus.update_en && (bus.kind_ex == 3'd1);
    // Saturated counters need no write; flush and INIT swallow updates silently.
    push_req   = (state == RUN) && !bus.flush_all && candidate && (ctr_new != pdch);
    push       = push_req && (!full || pop);
    drop       = push_req && !push;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (!bus.flush_all && sweep_last) state_nxt = RUN;
      RUN:     if (bus.flush_all) state_nxt = INIT;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    bus.pht_we    = 1'b0;
    bus.pht_waddr = '0;
    bus.pht_wdata = '0;
    bus.init_busy = 1'b0;
    case (state)
      INIT: begin
        bus.pht_we    = 1'b1;
        bus.pht_waddr = sweep_idx;
        bus.pht_wdata = 2'b01;
        bus.init_busy = 1'b1;
      end
      RUN: begin
        if (pop) begin
          bus.pht_we    = 1'b1;
          bus.pht_waddr = fifo_idx[rd_ptr];
          bus.pht_wdata = fifo_ctr[rd_ptr];
        end
      end
      default: ;
    endcase
  end

  assign bus.drop_cnt = drop_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sweep_idx     <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      deferred_last <= 1'b0;
      drop_q        <= '0;
    end else begin
      if ((state == INIT) && !bus.flush_all) sweep_idx <= sweep_idx + 1'b1;
      else                                   sweep_idx <= '0;

      if (bus.flush_all) begin
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        count         <= '0;
        deferred_last <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
        // A deferral forces the next cycle to write, so the head never starves.
        deferred_last <= (state == RUN) && !empty && defer;
      end

      if (drop && (drop_q != '1)) drop_q <= drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr] <= bus.pc_ex_bh_hashed;
      fifo_ctr[wr_ptr] <= ctr_new;
    end
  end

endmodule

// File: tb/tb_bpht_update_sched.sv
// Directed bench for bpht_update_sched: reset sweep, counter-update table, deferral,
// overflow drops, flush mid-drain and asynchronous reset mid-sweep.
module tb_bpht_update_sched;

  localparam int unsigned HW    = 4;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  bpht_update_sched_if #(.h_width(HW)) bus ();

  bpht_update_sched #(.h_width(HW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] kind;
    logic [3:0] idx;
    logic       taken;
    logic [1:0] pdch;
    logic       exp_we;
    logic [1:0] exp_data;
  } vec_t;

  vec_t       vt [9];
  logic [3:0] acc_idx [8];
  logic [1:0] acc_dat [8];
  logic [3:0] fl_pc [6];
  logic [31:0] fl_exp [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic we, input logic [3:0] a,
                                     input logic [1:0] d, input logic b);
    return {24'd0, we, a, d, b};
  endfunction

  function automatic logic [31:0] port_now();
    return {24'd0, bus.pht_we, bus.pht_waddr, bus.pht_wdata, bus.init_busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.update_en       = 1'b0;
    bus.kind_ex         = 3'd0;
    bus.pc_ex_bh_hashed = '0;
    bus.taken_real      = 1'b0;
    bus.taken_pdch_ex_b = 2'd0;
    bus.flush_all       = 1'b0;
    bus.pred_valid      = 1'b0;
    bus.pc_bh_hashed    = '0;
  endtask

  task automatic drive_upd(input logic [2:0] kind, input logic [3:0] idx,
                           input logic t, input logic [1:0] p);
    bus.update_en       = 1'b1;
    bus.kind_ex         = kind;
    bus.pc_ex_bh_hashed = idx;
    bus.taken_real      = t;
    bus.taken_pdch_ex_b = p;
  endtask

  // Expects to be called at the start of sweep cycle 0; returns at the start of cycle n.
  task automatic check_sweep(input int unsigned n, input string name);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s%0d", name, i), port_now(), pk(1'b1, i[3:0], 2'b01, 1'b1));
      tick();
    end
  endtask

  initial begin
    // kind, idx, taken, pdch, exp_we, exp_data
    vt[0] = '{3'd1, 4'h3, 1'b1, 2'd1, 1'b1, 2'd2};
    vt[1] = '{3'd1, 4'h4, 1'b0, 2'd0, 1'b0, 2'd0};
    vt[2] = '{3'd1, 4'h5, 1'b0, 2'd3, 1'b1, 2'd2};
    vt[3] = '{3'd4, 4'h6, 1'b1, 2'd1, 1'b0, 2'd0};
    vt[4] = '{3'd1, 4'h7, 1'b1, 2'd3, 1'b0, 2'd0};
    vt[5] = '{3'd1, 4'h7, 1'b1, 2'd0, 1'b1, 2'd1};
    vt[6] = '{3'd1, 4'h8, 1'b1, 2'd2, 1'b1, 2'd3};
    vt[7] = '{3'd1, 4'h9, 1'b0, 2'd2, 1'b1, 2'd1};
    vt[8] = '{3'd1, 4'hF, 1'b0, 2'd1, 1'b1, 2'd0};

    // Ten back-to-back updates k=0..9 (index k+1); k=7 and k=9 hit a full FIFO.
    acc_idx = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9};
    acc_dat = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2};

    fl_pc  = '{4'hB, 4'hB, 4'hB, 4'hC, 4'hC, 4'hD};
    fl_exp = '{32'd0, 32'd0, pk(1'b1, 4'hB, 2'd2, 1'b0), 32'd0,
               pk(1'b1, 4'hC, 2'd2, 1'b0), 32'd0};

    rstn = 1'b0;
    idle_inputs();
    repeat (3) tick();
    @(negedge clk);
    chk("reset_port", port_now(), pk(1'b1, 4'h0, 2'b01, 1'b1));
    chk("reset_drop", 32'(bus.drop_cnt), 32'd0);
    tick();
    rstn = 1'b1;

    check_sweep(16, "sweep");
    @(negedge clk);
    chk("sweep_done", port_now(), 32'd0);
    tick();

    for (int v = 0; v < 9; v++) begin
      drive_upd(vt[v].kind, vt[v].idx, vt[v].taken, vt[v].pdch);
      tick();
      idle_inputs();
      @(negedge clk);
      chk($sformatf("vec%0d", v), port_now(),
          pk(vt[v].exp_we, vt[v].exp_we ? vt[v].idx : 4'h0, vt[v].exp_data, 1'b0));
      tick();
    end

    // Index 0x2A folded to the 4-bit table.
    drive_upd(3'd1, 4'hA, 1'b1, 2'd1);
    tick();
    idle_inputs();
    bus.pred_valid   = 1'b1;
    bus.pc_bh_hashed = 4'hA;
    @(negedge clk); chk("conf_c1", port_now(), 32'd0);
    tick();
    @(negedge clk); chk("conf_c2", port_now(), pk(1'b1, 4'hA, 2'd2, 1'b0));
    tick();
    @(negedge clk); chk("conf_c3", port_now(), 32'd0);
    tick();
    idle_inputs();

    begin
      int nw;
      nw = 0;
      for (int c = 0; c < 17; c++) begin
        if (c < 10) drive_upd(3'd1, 4'(c + 1), (c % 2) == 0, ((c % 2) == 0) ? 2'd1 : 2'd2);
        else bus.update_en = 1'b0;
        bus.pred_valid   = 1'b1;
        bus.pc_bh_hashed = (nw < 8) ? acc_idx[nw] : 4'h0;
        @(negedge clk);
        if (c >= 2 && (c % 2) == 0 && nw < 8) begin
          chk($sformatf("ovf_w%0d", nw), port_now(), pk(1'b1, acc_idx[nw], acc_dat[nw], 1'b0));
          nw++;
        end else begin
          chk($sformatf("ovf_idle%0d", c), port_now(), 32'd0);
        end
        tick();
      end
    end
    idle_inputs();
    @(negedge clk);
    chk("ovf_drop", 32'(bus.drop_cnt), 32'd2);
    chk("ovf_empty", port_now(), 32'd0);
    tick();

    for (int c = 0; c < 6; c++) begin
      if (c < 5) drive_upd(3'd1, 4'(11 + c), 1'b1, 2'd1);
      else begin
        drive_upd(3'd1, 4'h3, 1'b1, 2'd1);
        bus.flush_all = 1'b1;
      end
      bus.pred_valid   = 1'b1;
      bus.pc_bh_hashed = fl_pc[c];
      @(negedge clk);
      chk($sformatf("flush_c%0d", c), port_now(), fl_exp[c]);
      tick();
    end
    idle_inputs();
    check_sweep(16, "flsweep");
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("flush_after%0d", c), port_now(), 32'd0);
      tick();
    end
    @(negedge clk);
    chk("flush_drop", 32'(bus.drop_cnt), 32'd2);

    tick();
    bus.flush_all = 1'b1;
    @(negedge clk);
    chk("flush2_cycle", port_now(), 32'd0);
    tick();
    bus.flush_all = 1'b0;
    check_sweep(4, "sw2_");
    bus.flush_all = 1'b1;
    @(negedge clk);
    chk("init_flush_cycle", port_now(), pk(1'b1, 4'h4, 2'b01, 1'b1));
    tick();
    bus.flush_all = 1'b0;
    check_sweep(7, "restart");
    @(negedge clk);
    chk("pre_areset", port_now(), pk(1'b1, 4'h7, 2'b01, 1'b1));
    #1 rstn = 1'b0;
    #1;
    chk("areset_port", port_now(), pk(1'b1, 4'h0, 2'b01, 1'b1));
    chk("areset_drop", 32'(bus.drop_cnt), 32'd0);
    tick();
    tick();
    rstn = 1'b1;
    check_sweep(16, "resweep");
    @(negedge clk);
    chk("resweep_done", port_now(), 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
